frame_scoreboard: RTL

FRAME_SCOREBOARD -- requirements
Module: frame_scoreboard

---
 rtl/frame_scoreboard.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_scoreboard.sv
// frame_scoreboard: paces the physics engine at a fixed frame rate, keeps the
// match score and state, and double-buffers object positions so the renderer
// only ever sees a complete physics frame latched on a vsync rising edge.
module frame_scoreboard #(
  parameter int TICK_DIV    = 1666667,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vsync_in,
  input  logic       valid,
  input  logic [9:0] p1_pos_x,
  input  logic [9:0] p1_pos_y,
  input  logic [9:0] p2_pos_x,
  input  logic [9:0] p2_pos_y,
  input  logic [9:0] ball_pos_x,
  input  logic [9:0] ball_pos_y,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic       en,
  output logic [9:0] snap_p1_x,
  output logic [9:0] snap_p1_y,
  output logic [9:0] snap_p2_x,
  output logic [9:0] snap_p2_y,
  output logic [9:0] snap_ball_x,
  output logic [9:0] snap_ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic [1:0] match_winner
);

  localparam int FW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HOLD = 2'b10,
    OVER = 2'b11
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [FW-1:0]   frame_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            go_prev;
  logic            vs_prev;
  logic            pending;
  logic [9:0]      sh_p1_x, sh_p1_y, sh_p2_x, sh_p2_y, sh_ball_x, sh_ball_y;

  logic            wrap;
  logic            go_rise;
  logic            vs_rise;
  logic            inc_p1;
  logic            inc_p2;
  logic            win_p1;
  logic            win_p2;
  logic            hold_clr;
  logic            clear_match;

  assign wrap    = (frame_cnt == FRAME_LAST);
  assign go_rise = game_over & ~go_prev;
  assign vs_rise = vsync_in & ~vs_prev;
  assign state   = state_q;

  // Free-running frame divider; never disturbed by state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (wrap) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + FW'(1);
  end

  // Edge-detect history for game_over and vsync_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      go_prev <= game_over;
      vs_prev <= vsync_in;
    end
  end

  // Match state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next-state and score-event decode; a point that reaches WIN ends the match.
  always_comb begin
    state_d     = state_q;
    inc_p1      = 1'b0;
    inc_p2      = 1'b0;
    win_p1      = 1'b0;
    win_p2      = 1'b0;
    hold_clr    = 1'b0;
    clear_match = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = PLAY;
      PLAY: begin
        if (go_rise && winner == 2'd1) begin
          inc_p1 = 1'b1;
          if (p1_score >= WIN - 4'd1) begin
            win_p1  = 1'b1;
            state_d = OVER;
          end else begin
            hold_clr = 1'b1;
            state_d  = HOLD;
          end
        end else if (go_rise && winner == 2'd2) begin
          inc_p2 = 1'b1;
          if (p2_score >= WIN - 4'd1) begin
            win_p2  = 1'b1;
            state_d = OVER;
          end else begin
            hold_clr = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: if (wrap && hold_cnt == HOLD_LAST) state_d = PLAY;
      OVER: begin
        if (start) begin
          clear_match = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Physics trigger: one registered pulse per frame while playing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en <= 1'b0;
    else en <= wrap && (state_q == PLAY);
  end

  // Counts frame wraps spent frozen after a point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else if (hold_clr) hold_cnt <= '0;
    else if (state_q == HOLD && wrap && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HW'(1);
  end

  // Scores saturate at WIN; the match winner is latched as the match ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_score     <= 4'd0;
      p2_score     <= 4'd0;
      match_winner <= 2'd0;
    end else if (clear_match) begin
      p1_score     <= 4'd0;
      p2_score     <= 4'd0;
      match_winner <= 2'd0;
    end else begin
      if (inc_p1 && p1_score < WIN) p1_score <= p1_score + 4'd1;
      if (inc_p2 && p2_score < WIN) p2_score <= p2_score + 4'd1;
      if (win_p1) match_winner <= 2'd1;
      else if (win_p2) match_winner <= 2'd2;
    end
  end

  // Shadow capture on valid; snapshots move on a vsync edge only if a new
  // frame is waiting, and a coincident valid keeps the next frame pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      sh_p1_x     <= '0;
      sh_p1_y     <= '0;
      sh_p2_x     <= '0;
      sh_p2_y     <= '0;
      sh_ball_x   <= '0;
      sh_ball_y   <= '0;
      snap_p1_x   <= '0;
      snap_p1_y   <= '0;
      snap_p2_x   <= '0;
      snap_p2_y   <= '0;
      snap_ball_x <= '0;
      snap_ball_y <= '0;
    end else begin
      if (vs_rise && pending) begin
        snap_p1_x   <= sh_p1_x;
        snap_p1_y   <= sh_p1_y;
        snap_p2_x   <= sh_p2_x;
        snap_p2_y   <= sh_p2_y;
        snap_ball_x <= sh_ball_x;
        snap_ball_y <= sh_ball_y;
        pending     <= 1'b0;
      end
      if (valid) begin
        sh_p1_x   <= p1_pos_x;
        sh_p1_y   <= p1_pos_y;
        sh_p2_x   <= p2_pos_x;
        sh_p2_y   <= p2_pos_y;
        sh_ball_x <= ball_pos_x;
        sh_ball_y <= ball_pos_y;
        pending   <= 1'b1;
      end
    end
  end

endmodule
